// File: rtl/sti4_share_gen.sv
// sti4_share_gen: splits each input nibble into two Boolean shares using a 16-bit LFSR mask, with a valid/ready handshake on both sides.
// Ports: clk, rst_n (async active-low); seed_load/seed reseed the LFSR;
// in_valid/in_ready/in_nib form the input handshake; out_valid/out_ready/out_shares
// ({share1, share0}) form the output handshake; acc_cnt counts accepted nibbles.
module sti4_share_gen #(
  parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seed_load,
  input  logic [15:0] seed,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_nib,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_shares,
  output logic [7:0]  acc_cnt
);
  typedef enum logic {RUN, LOAD} state_t;
  state_t      r_state, w_next;
  logic [15:0] r_lfsr;
  logic        r_valid;
  logic [7:0]  r_shares, r_cnt;
  logic        w_accept, w_reseed;
  function automatic logic [15:0] lfsr_adv4(input logic [15:0] s);
    logic [15:0] t;
    t = s;
    for (int k = 0; k < 4; k++) t = {t[14:0], t[15] ^ t[13] ^ t[12] ^ t[10]};
    return t;
  endfunction
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= RUN;
    else r_state <= w_next;
  always_comb w_next = (r_state == RUN && seed_load) ? LOAD : RUN;
  always_comb in_ready = (r_state == RUN) && !seed_load && (!r_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_reseed = (r_state == RUN) && seed_load;
  // share0 is the raw mask only; the nibble enters share1 alone
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_lfsr   <= SEED_DEFAULT;
      r_valid  <= 1'b0;
      r_shares <= 8'h00;
      r_cnt    <= 8'h00;
    end else begin
      if (w_reseed) r_lfsr <= (seed == 16'h0000) ? SEED_DEFAULT : seed;
      else if (w_accept) r_lfsr <= lfsr_adv4(r_lfsr);
      if (w_accept) begin
        r_shares <= {in_nib ^ r_lfsr[3:0], r_lfsr[3:0]};
        r_valid  <= 1'b1;
        r_cnt    <= r_cnt + 8'd1;
      end else if (r_valid && out_ready) r_valid <= 1'b0;
    end
  assign out_valid  = r_valid;
  assign out_shares = r_shares;
  assign acc_cnt    = r_cnt;
endmodule

// File: tb/tb_sti4_share_gen.sv
// tb_sti4_share_gen: randomized and directed checks of sti4_share_gen against a transaction-level model.
module tb_sti4_share_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic seed_load = 1'b0;
  logic [15:0] seed = 16'h0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [3:0] in_nib = 4'h0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [7:0] out_shares, acc_cnt;
  int errs = 0, checks = 0, nacc = 0;
  logic m_load, m_valid;
  logic [7:0] m_sh, m_cnt;
  logic [15:0] m_lfsr;
  logic [3:0] q[$];

  sti4_share_gen dut (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed),
    .in_valid(in_valid), .in_ready(in_ready), .in_nib(in_nib),
    .out_valid(out_valid), .out_ready(out_ready), .out_shares(out_shares),
    .acc_cnt(acc_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // x^16 + x^14 + x^13 + x^11 + 1 style shift: feedback is parity of taps 15,13,12,10
  function automatic logic [15:0] ref_adv4(input logic [15:0] s);
    logic [15:0] t;
    t = s;
    repeat (4) t = {t[14:0], ^(t & 16'hB400)};
    return t;
  endfunction

  task automatic model_reset();
    m_load = 0; m_valid = 0; m_sh = 8'h00; m_cnt = 8'h00; m_lfsr = 16'hACE1;
    q.delete();
  endtask

  task automatic cyc();
    logic er, acc, cons;
    logic [3:0] nib;
    #1;
    er = !m_load && !seed_load && (!m_valid || out_ready);
    chk("in_ready", in_ready, er);
    acc = in_valid && er;
    cons = m_valid && out_ready;
    if (cons && q.size() > 0) begin
      nib = q.pop_front();
      chk("share_xor", out_shares[7:4] ^ out_shares[3:0], nib);
    end
    @(posedge clk);
    #1;
    if (acc) begin
      m_sh = {in_nib ^ m_lfsr[3:0], m_lfsr[3:0]};
      m_valid = 1; m_cnt++; nacc++;
      q.push_back(in_nib);
    end else if (cons) m_valid = 0;
    if (!m_load && seed_load) begin
      m_load = 1;
      m_lfsr = (seed == 16'h0) ? 16'hACE1 : seed;
    end else begin
      m_load = 0;
      if (acc) m_lfsr = ref_adv4(m_lfsr);
    end
    chk("out_valid", out_valid, m_valid);
    chk("out_shares", out_shares, m_sh);
    chk("acc_cnt", acc_cnt, m_cnt);
  endtask

  task automatic do_reset();
    rst_n = 0; seed_load = 0; in_valid = 0; out_ready = 0;
    @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_shares", out_shares, 8'h00);
    chk("rst_cnt", acc_cnt, 8'h00);
    model_reset();
    rst_n = 1;
  endtask

  initial begin
    int cyc_n;
    model_reset();
    do_reset();
    in_valid = 1; in_nib = 4'hA; out_ready = 1;
    cyc();
    chk("r031_shares", out_shares, 8'hB1);
    chk("r031_cnt", acc_cnt, 8'd1);
    in_nib = 4'h3;
    cyc();
    chk("r032_shares", out_shares, 8'hDE);
    out_ready = 0; in_nib = 4'h5;
    repeat (5) cyc();
    chk("r033_stable", out_shares, 8'hDE);
    out_ready = 1;
    cyc();
    chk("r033_resume_cnt", acc_cnt, 8'd3);
    seed_load = 1; seed = 16'h0000; in_nib = 4'h7;
    cyc();
    seed_load = 0;
    cyc();
    chk("r034_cnt", acc_cnt, 8'd3);
    in_nib = 4'hA;
    cyc();
    chk("r034_shares", out_shares, 8'hB1);
    out_ready = 0; in_nib = 4'h7;
    cyc();
    chk("r036_pending", out_valid, 1);
    rst_n = 0;
    #1;
    chk("r036_valid", out_valid, 0);
    chk("r036_shares", out_shares, 8'h00);
    chk("r036_cnt", acc_cnt, 8'h00);
    model_reset();
    #2 rst_n = 1;
    in_valid = 0;
    cyc();
    do_reset();
    nacc = 0;
    cyc_n = 0;
    while (nacc < 1000 && cyc_n < 20000) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      in_nib    = 4'($urandom_range(0, 15));
      seed_load = ($urandom_range(0, 99) < 3);
      seed      = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      if (nacc == 999 && in_valid) seed_load = 0;
      cyc();
      cyc_n++;
    end
    chk("r035_accepts", nacc, 1000);
    in_valid = 0; seed_load = 0; out_ready = 1;
    repeat (3) cyc();
    chk("r035_cnt", acc_cnt, 8'hE8);
    chk("r035_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/sti4_share_gen.md
STI4_SHARE_GEN -- requirements
Module: sti4_share_gen

Interface
REQ-001 SHALL have parameter SEED_DEFAULT, default 16'hACE1: the LFSR value after reset, also used when a zero seed is loaded.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port seed_load, input, 1 bit: requests loading of seed into the LFSR.
REQ-005 SHALL have port seed, input, 16 bits: the new LFSR state.
REQ-006 SHALL have port in_valid, input, 1 bit: in_nib is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts in_nib this cycle.
REQ-008 SHALL have port in_nib, input, 4 bits: unmasked S-box input nibble.
REQ-009 SHALL have port out_valid, output, 1 bit: out_shares holds valid data.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer takes out_shares this cycle.
REQ-011 SHALL have port out_shares, output, 8 bits: {share1, share0}, the 8-bit shared word fed to the 4-bit TI component functions.
REQ-012 SHALL have port acc_cnt, output, 8 bits: count of accepted nibbles.

Function
REQ-013 SHALL implement a two-state FSM, RUN and LOAD; reset state is RUN.
REQ-014 In RUN, seed_load=1 SHALL cause a transition to LOAD on the next edge; LOAD SHALL last exactly one cycle and then return to RUN.
REQ-015 On the RUN->LOAD edge, the LFSR SHALL take the value seed, or SEED_DEFAULT if seed==16'h0000.
REQ-016 seed_load SHALL be ignored while in LOAD.
REQ-017 in_ready SHALL equal (state==RUN) && !seed_load && (!out_valid || out_ready), combinationally.
REQ-018 An accept SHALL be a cycle with in_valid && in_ready; output data SHALL appear one cycle after the accept.
REQ-019 On accept, with mask m = lfsr[3:0] (value before the update), out_shares SHALL become {in_nib ^ m, m} and out_valid SHALL be set.
REQ-020 On accept, the LFSR SHALL advance 4 steps (single step: fb = s[15]^s[13]^s[12]^s[10]; s <= {s[14:0], fb}). This equals {s[11:0], f1..f4} with the bits computed sequentially.
REQ-021 Without an accept, the LFSR SHALL hold its value.
REQ-022 When out_valid && out_ready and there is no accept in the same cycle, out_valid SHALL clear; out_shares SHALL hold its last value.
REQ-023 Simultaneous accept and consume (out_ready=1, out_valid=1) SHALL replace the data with no bubble, giving full throughput of 1 nibble/cycle.
REQ-024 While out_valid && !out_ready, out_shares and out_valid SHALL remain stable.
REQ-025 acc_cnt SHALL increment by 1 per accept and wrap 8'hFF -> 8'h00.
REQ-026 The combination share1 ^ share0 SHALL always equal the accepted in_nib.
REQ-027 share0 alone SHALL never be driven by in_nib, to preserve non-completeness for the downstream TI.

Reset
REQ-028 While rst_n=0, regardless of clk: lfsr=SEED_DEFAULT, state=RUN, out_valid=0, out_shares=8'h00, acc_cnt=8'h00.
REQ-029 Assertion of rst_n during a pending output or during LOAD SHALL discard it immediately, with no output handshake completing.
REQ-030 The first accept after reset deassertion SHALL be possible on the first clock edge with rst_n=1.

Verification
REQ-031 Reset, then in_nib=4'hA accepted with out_ready=1 -> out_shares=8'hB1 the next cycle, out_valid=1, acc_cnt=1, LFSR=16'hCE1E.
REQ-032 Back-to-back accepts of 4'hA then 4'h3 -> 8'hB1 then 8'hDE on consecutive cycles, in_ready held at 1.
REQ-033 out_ready=0 with data pending -> in_ready=0 and out_shares stable for 5 cycles; the LFSR does not advance; after out_ready=1 the next accept proceeds.
REQ-034 seed_load=1 with seed=16'h0000 while in_valid=1 -> no accept in that cycle or the LOAD cycle, LFSR=16'hACE1; the next nibble 4'hA gives 8'hB1.
REQ-035 1000 random nibbles with random backpressure -> every output has share1^share0 equal to its input in order, and acc_cnt = 1000 mod 256 = 8'hE8.
REQ-036 rst_n pulsed low while out_valid=1 and out_ready=0 -> out_valid=0 and out_shares=8'h00 immediately, with no clock edge needed.
